// File: rtl/aurora_tx_lane_gearbox.sv
// Aurora 64b/66b transmit lane: scrambles 66-bit blocks, inserts idle blocks and gearboxes them to 32-bit words.
// Build option AURORA_TX_PRBS_EN adds prbs_en_i and a PRBS7 test-pattern generator.
module aurora_tx_lane_gearbox #(
  parameter logic [63:0] IDLE_DATA = 64'h7800_0000_0000_0000,
  parameter logic [57:0] SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic        clk_tx_i,
  input  logic        rst_n_i,
  input  logic [63:0] tx_data_i,
  input  logic [1:0]  tx_header_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic        tx_polarity_i,
`ifdef AURORA_TX_PRBS_EN
  input  logic        prbs_en_i,
`endif
  output logic [31:0] tx_data_o,
  output logic [7:0]  tx_stat_o
);

  // Handshake: a block on tx_data_i/tx_header_i is consumed on the rising edge
  // where tx_valid_i=1 and tx_ready_o=1; tx_ready_o never looks at tx_valid_i.
  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  fill_q, fill_d;
  logic [97:0] acc_q, acc_d;
  logic [57:0] scr_q, scr_d;
  logic [5:0]  seq_q;
  logic        idle_q;
  logic [31:0] data_q, word_d;
  logic        run, prbs_act, advance, load;
  logic [63:0] pay_raw, pay_scr;
  logic [65:0] blk;
  logic [97:0] merged;
  logic [31:0] prbs_word;

  always_ff @(posedge clk_tx_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_HALT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_HALT) state_d = ST_RUN;
  end

  assign run = (state_q == ST_RUN);

`ifdef AURORA_TX_PRBS_EN
  logic [6:0] prbs_q, prbs_d;

  assign prbs_act = run & prbs_en_i;

  // x^7+x^6+1, newest bit placed MSB-first in the word
  always_comb begin
    prbs_d    = prbs_q;
    prbs_word = '0;
    for (int i = 31; i >= 0; i--) begin
      prbs_word[i] = prbs_d[6] ^ prbs_d[5];
      prbs_d       = {prbs_d[5:0], prbs_word[i]};
    end
  end

  always_ff @(posedge clk_tx_i or negedge rst_n_i) begin
    if (!rst_n_i)      prbs_q <= 7'h7F;
    else if (prbs_act) prbs_q <= prbs_d;
  end
`else
  assign prbs_act  = 1'b0;
  assign prbs_word = '0;
`endif

  assign advance    = run & ~prbs_act;
  assign load       = advance & (fill_q < 7'd32);
  assign tx_ready_o = load;

  assign pay_raw = tx_valid_i ? tx_data_i : IDLE_DATA;

  // Self-synchronous scrambler, bit 63 first; state holds the scrambled history, newest in bit 0.
  always_comb begin
    scr_d   = scr_q;
    pay_scr = '0;
    for (int i = 63; i >= 0; i--) begin
      pay_scr[i] = pay_raw[i] ^ scr_d[38] ^ scr_d[57];
      scr_d      = {scr_d[56:0], pay_scr[i]};
    end
  end

  assign blk    = {(tx_valid_i ? tx_header_i : 2'b10), pay_scr};
  assign merged = acc_q | ({blk, 32'b0} >> fill_q);

  // Accumulator is MSB-aligned; the word always comes off the top 32 bits.
  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    word_d = acc_q[97:66];
    if (load) begin
      word_d = merged[97:66];
      acc_d  = {merged[65:0], 32'b0};
      fill_d = fill_q + 7'd34;
    end else if (advance) begin
      acc_d  = {acc_q[65:0], 32'b0};
      fill_d = fill_q - 7'd32;
    end
    if (prbs_act) word_d = prbs_word;
  end

  always_ff @(posedge clk_tx_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q  <= '0;
      fill_q <= '0;
      scr_q  <= SCR_SEED;
      seq_q  <= '0;
      idle_q <= 1'b0;
      data_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      if (load) begin
        scr_q  <= scr_d;
        idle_q <= ~tx_valid_i;
      end
      if (advance) seq_q <= (seq_q == 6'd32) ? 6'd0 : seq_q + 6'd1;
      if (advance | prbs_act) data_q <= word_d ^ {32{tx_polarity_i}};
    end
  end

  assign tx_data_o = data_q;
  assign tx_stat_o = {seq_q, idle_q, run};

endmodule

// File: tb/tb_aurora_tx_lane_gearbox.sv
// Bench for aurora_tx_lane_gearbox: scoreboard of loaded blocks, recovered by deserialising and descrambling tx_data_o.
// PRBS section is compiled only with AURORA_TX_PRBS_EN.
module tb_aurora_tx_lane_gearbox;

  localparam logic [63:0] IDLE_DATA = 64'h7800_0000_0000_0000;
  localparam logic [57:0] SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF;

  logic        clk_tx_i = 1'b0;
  logic        rst_n_i  = 1'b0;
  logic [63:0] tx_data_i = '0;
  logic [1:0]  tx_header_i = 2'b01;
  logic        tx_valid_i = 1'b0;
  logic        tx_ready_o;
  logic        tx_polarity_i = 1'b0;
`ifdef AURORA_TX_PRBS_EN
  logic        prbs_en_i = 1'b0;
`endif
  logic [31:0] tx_data_o;
  logic [7:0]  tx_stat_o;

  aurora_tx_lane_gearbox dut (
    .clk_tx_i      (clk_tx_i),
    .rst_n_i       (rst_n_i),
    .tx_data_i     (tx_data_i),
    .tx_header_i   (tx_header_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .tx_polarity_i (tx_polarity_i),
`ifdef AURORA_TX_PRBS_EN
    .prbs_en_i     (prbs_en_i),
`endif
    .tx_data_o     (tx_data_o),
    .tx_stat_o     (tx_stat_o)
  );

  // clock / reset
  always #5 clk_tx_i = ~clk_tx_i;

  // scoreboard and reference model state
  logic [65:0] exp_q[$];
  logic        bit_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        m_run = 1'b0;
  int          m_fill = 0;
  logic [5:0]  m_seq = '0;
  logic        m_idle = 1'b0;
  logic [57:0] dscr = SCR_SEED;
  logic [6:0]  prbs_h = 7'h7F;
  int          blocks_rx = 0;
  int          rdy_cnt = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drain_blocks();
    logic [65:0] blk;
    logic        r;
    while (bit_q.size() >= 66) begin
      blk[65] = bit_q.pop_front();
      blk[64] = bit_q.pop_front();
      for (int i = 63; i >= 0; i--) begin
        r      = bit_q.pop_front();
        blk[i] = r ^ dscr[38] ^ dscr[57];
        dscr   = {dscr[56:0], r};
      end
      blocks_rx++;
      check_eq("exp_q_nonempty", 128'(exp_q.size() > 0), 128'(1'b1));
      if (exp_q.size() > 0) check_eq("block", 128'(blk), 128'(exp_q.pop_front()));
    end
  endtask

  // one clock of stimulus, model update and output capture; entered and left at a falling edge
  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d,
                      input logic pol, input logic prbs, output logic accepted);
    int          kind;
    logic [31:0] w, ew;
    logic [6:0]  g;
    tx_valid_i    = v;
    tx_header_i   = h;
    tx_data_i     = d;
    tx_polarity_i = pol;
`ifdef AURORA_TX_PRBS_EN
    prbs_en_i     = prbs;
`endif
    #1;
    check_eq("ready", 128'(tx_ready_o), 128'(m_run && (m_fill < 32) && !prbs));
    check_eq("stat", 128'(tx_stat_o), 128'({m_seq, m_idle, m_run}));
    if (tx_ready_o) rdy_cnt++;
    accepted = 1'b0;
    kind     = 0;
    if (m_run && prbs) begin
      kind = 2;
    end else if (m_run) begin
      kind = 1;
      if (m_fill < 32) begin
        exp_q.push_back(v ? {h, d} : {2'b10, IDLE_DATA});
        m_idle   = ~v;
        accepted = v;
        m_fill   = m_fill + 34;
      end else begin
        m_fill = m_fill - 32;
      end
      m_seq = (m_seq == 6'd32) ? 6'd0 : m_seq + 6'd1;
    end else begin
      m_run = 1'b1;
    end
    @(posedge clk_tx_i);
    @(negedge clk_tx_i);
    w = tx_data_o ^ {32{pol}};
    if (kind == 1) begin
      for (int i = 31; i >= 0; i--) bit_q.push_back(w[i]);
      drain_blocks();
    end else if (kind == 2) begin
      g  = prbs_h;
      ew = '0;
      for (int i = 31; i >= 0; i--) begin
        ew[i] = g[6] ^ g[5];
        g     = {g[5:0], ew[i]};
      end
      check_eq("prbs_word", 128'(w), 128'(ew));
      for (int i = 31; i >= 0; i--) prbs_h = {prbs_h[5:0], w[i]};
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_fill = 0;
    m_seq  = '0;
    m_idle = 1'b0;
    dscr   = SCR_SEED;
    prbs_h = 7'h7F;
    exp_q.delete();
    bit_q.delete();
  endtask

  // random-traffic driver: a pending block is held until it is accepted
  logic [1:0]  p_hdr;
  logic [63:0] p_dat;
  logic        pol_r = 1'b0;

  task automatic new_block();
    p_hdr = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    p_dat = {$urandom, $urandom};
  endtask

  task automatic random_traffic(input int cycles, input bit flip_pol);
    logic acc;
    for (int i = 0; i < cycles; i++) begin
      if (flip_pol && $urandom_range(0, 7) == 0) pol_r = ~pol_r;
      step($urandom_range(0, 1) == 1, p_hdr, p_dat, pol_r, 1'b0, acc);
      if (acc) new_block();
    end
  endtask

  initial begin
    logic        acc;
    logic [31:0] cnt;

    repeat (3) @(negedge clk_tx_i);
    check_eq("reset_data", 128'(tx_data_o), 128'(0));
    check_eq("reset_ready", 128'(tx_ready_o), 128'(0));
    check_eq("reset_stat", 128'(tx_stat_o), 128'(0));
    rst_n_i = 1'b1;

    // idle-only stream
    for (int i = 0; i < 1000; i++) step(1'b0, 2'b01, 64'h0, 1'b0, 1'b0, acc);

    // back-to-back data blocks with a 16-in-33 ready window check
    cnt = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if (i == 40) rdy_cnt = 0;
      step(1'b1, 2'b01, {cnt, cnt}, 1'b0, 1'b0, acc);
      if (acc) cnt = cnt + 32'd1;
      if (i == 40 + 330 - 1) check_eq("ready_16_of_33", 128'(rdy_cnt), 128'(160));
    end

    new_block();
    random_traffic(600, 1'b0);
    random_traffic(200, 1'b1);
    pol_r = 1'b0;

`ifdef AURORA_TX_PRBS_EN
    for (int i = 0; i < 100; i++) step(1'b1, p_hdr, p_dat, 1'b0, 1'b1, acc);
    random_traffic(200, 1'b0);
`endif

    // reset in the middle of a cycle while blocks are in flight
    @(posedge clk_tx_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("midrst_data", 128'(tx_data_o), 128'(0));
    check_eq("midrst_ready", 128'(tx_ready_o), 128'(0));
    check_eq("midrst_stat", 128'(tx_stat_o), 128'(0));
    @(negedge clk_tx_i);
    model_reset();
    repeat (2) @(negedge clk_tx_i);
    rst_n_i = 1'b1;
    random_traffic(300, 1'b1);

    check_eq("backlog_le2", 128'(exp_q.size() <= 2), 128'(1'b1));
    check_eq("blocks_seen", 128'(blocks_rx > 1000), 128'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
